axis_pkt_gen: RTL

- AXI-Stream packet source (master) that drives the write side of the team's AXIS packet FIFOs and any other AXIS sink.
- Generates a configurable number of packets of configurable length, with a selectable data pattern, correct tlast, and an optional inter-packet gap.
- Honors sink backpressure on every beat.
- Used as the stimulus/traffic block for FIFO bring-up on hardware and in simulation.

---
 rtl/axis_gen_pkg.sv | 22 ++
 rtl/axis_lfsr32.sv | 27 ++
 rtl/axis_pkt_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/axis_gen_pkg.sv
// Shared constants for the AXIS packet generator and its companion checker:
// FSM encodings, data pattern selectors and LFSR definition.
package axis_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] PAT_WORD     = 2'd0;
  localparam logic [1:0] PAT_BEAT     = 2'd1;
  localparam logic [1:0] PAT_LFSR     = 2'd2;
  localparam logic [1:0] PAT_WORD_ALT = 2'd3;

  // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {1'b0, cur[31:1]} ^ ({32{cur[0]}} & LFSR_POLY);
  endfunction

endpackage

// File: rtl/axis_lfsr32.sv
// 32-bit Galois LFSR with a synchronous load and an advance enable; load wins.
module axis_lfsr32
  import axis_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      lfsr_q <= load_value;
    end else if (advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: runs of fixed-length packets with selectable data
// pattern and optional idle gap, ending on packet count or at a packet boundary after stop.
module axis_pkt_gen
  import axis_gen_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int LenWidth  = 16,
  parameter int GapWidth  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LenWidth-1:0]  cfg_pkt_len,
  input  logic [LenWidth-1:0]  cfg_pkt_count,
  input  logic [GapWidth-1:0]  cfg_gap,
  input  logic [1:0]           cfg_pattern,
  input  logic [31:0]          cfg_seed,
  output logic [DataWidth-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 busy,
  output logic                 done,
  output logic [LenWidth-1:0]  pkt_sent
);

  logic [1:0]           state;
  logic [LenWidth-1:0]  len_q;
  logic [LenWidth-1:0]  count_q;
  logic [GapWidth-1:0]  gap_q;
  logic [1:0]           pattern_q;
  logic [LenWidth-1:0]  beat;
  logic [DataWidth-1:0] word;
  logic [GapWidth-1:0]  gap_cnt;
  logic                 stop_pend;
  logic                 done_q;
  logic [LenWidth-1:0]  pkt_sent_q;

  logic [31:0]          lfsr_value;
  logic [31:0]          seed_fixed;
  logic                 sending;
  logic                 xfer;
  logic                 last_beat;
  logic                 run_end;
  logic                 lfsr_load;
  logic [DataWidth-1:0] beat_ext;
  logic [DataWidth-1:0] lfsr_ext;

  assign sending    = (state == ST_SEND);
  assign xfer       = sending & m_tready;
  assign last_beat  = (beat == (len_q - LenWidth'(1)));
  assign lfsr_load  = (state == ST_IDLE) & start;
  assign seed_fixed = (cfg_seed == 32'h0) ? LFSR_DEFAULT_SEED : cfg_seed;

  // A stop arriving on the tlast beat itself ends the run at that same boundary.
  assign run_end = ((count_q != '0) && ((pkt_sent_q + LenWidth'(1)) == count_q))
                   || stop_pend || stop;

  generate
    if (DataWidth > LenWidth) begin : g_beat_pad
      assign beat_ext = {{(DataWidth-LenWidth){1'b0}}, beat};
    end else begin : g_beat_trunc
      assign beat_ext = beat[DataWidth-1:0];
    end
    if (DataWidth > 32) begin : g_lfsr_pad
      assign lfsr_ext = {{(DataWidth-32){1'b0}}, lfsr_value};
    end else begin : g_lfsr_trunc
      assign lfsr_ext = lfsr_value[DataWidth-1:0];
    end
  endgenerate

  axis_lfsr32 u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (lfsr_load),
    .load_value (seed_fixed),
    .advance    (xfer),
    .value      (lfsr_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      len_q      <= LenWidth'(1);
      count_q    <= '0;
      gap_q      <= '0;
      pattern_q  <= PAT_WORD;
      beat       <= '0;
      word       <= '0;
      gap_cnt    <= '0;
      stop_pend  <= 1'b0;
      done_q     <= 1'b0;
      pkt_sent_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q      <= (cfg_pkt_len == '0) ? LenWidth'(1) : cfg_pkt_len;
            count_q    <= cfg_pkt_count;
            gap_q      <= cfg_gap;
            pattern_q  <= cfg_pattern;
            beat       <= '0;
            word       <= '0;
            pkt_sent_q <= '0;
            stop_pend  <= stop;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (xfer) begin
            word <= word + DataWidth'(1);
            beat <= beat + LenWidth'(1);
            if (last_beat) begin
              beat       <= '0;
              pkt_sent_q <= pkt_sent_q + LenWidth'(1);
              if (run_end) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end else if (gap_q != '0) begin
                state   <= ST_GAP;
                gap_cnt <= gap_q;
              end
            end
          end
        end
        ST_GAP: begin
          // A stop here is already on a packet boundary, so end immediately.
          if (stop) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else if (gap_cnt == GapWidth'(1)) begin
            state <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt - GapWidth'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_tdata = '0;
    if (sending) begin
      case (pattern_q)
        PAT_BEAT: m_tdata = beat_ext;
        PAT_LFSR: m_tdata = lfsr_ext;
        default:  m_tdata = word;
      endcase
    end
  end

  assign m_tvalid = sending;
  assign m_tlast  = sending & last_beat;
  assign busy     = (state != ST_IDLE);
  assign done     = done_q;
  assign pkt_sent = pkt_sent_q;

endmodule
